// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the sequential multiplier.
//   MUL_N    default operand width
//   state_t  control FSM encoding (IDLE/RUN/DONE; code 3 is unused and
//            treated as IDLE by the FSM)
package mul_pkg;

    localparam int MUL_N = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : mul_pkg

// File: rtl/rca_n.sv
// rca_n: N-bit combinational ripple-carry adder made of full-adder cells.
// Ports:
//   a, b  input  [N-1:0]  addends
//   ci    input           carry in
//   s     output [N-1:0]  sum
//   co    output          carry out of the top cell
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] carry;

    assign carry[0] = ci;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = carry[N];

endmodule : rca_n

// File: rtl/seq_mul4.sv
// seq_mul4: sequential shift-and-add unsigned multiplier.
// One adder pass per RUN cycle; an N x N product appears N clocks after
// the accepting edge, flagged by a one-cycle done pulse.
// Ports:
//   clk      input            clock, rising edge
//   rst      input            synchronous active-high reset
//   start    input            request, sampled only in IDLE
//   a        input  [N-1:0]   multiplicand, captured on the accepting edge
//   b        input  [N-1:0]   multiplier, captured on the accepting edge
//   busy     output           high in RUN and DONE
//   done     output           one-cycle pulse, product is new
//   product  output [2N-1:0]  a*b, held until the next completion
module seq_mul4
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t         state_reg, state_next;
    logic [N-1:0]   m_reg, m_next;
    // {HI, LO}. The adder carry C only lives between the add and the shift
    // of one iteration: the shift always moves it into HI's MSB, so the
    // stored C bit would always be 0 and is not kept.
    logic [2*N-1:0] acc_reg, acc_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*N-1:0] product_reg, product_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    logic [N-1:0]   hi, lo;
    logic [N-1:0]   sum;
    logic           co;
    logic [N:0]     c_hi;       // {C, HI} after the conditional add
    logic [2*N-1:0] shifted;    // {HI, LO} after the right shift

    assign hi = acc_reg[2*N-1:N];
    assign lo = acc_reg[N-1:0];

    rca_n #(.N(N)) u_add (
        .a  (hi),
        .b  (m_reg),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    always_comb begin
        c_hi    = lo[0] ? {co, sum} : {1'b0, hi};
        // 0 shifts into the MSB of {C,HI,LO}; it drops out of the 2N-bit view.
        shifted = {c_hi, lo[N-1:1]};
    end

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        busy_next    = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            S_RUN: begin
                busy_next = 1'b1;
                acc_next  = shifted;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next   = S_DONE;
                    product_next = shifted;
                    done_next    = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                // IDLE, and the unused code 3 which behaves as IDLE
                state_next = S_IDLE;
                if (start) begin
                    state_next = S_RUN;
                    m_next     = a;
                    acc_next   = {{N{1'b0}}, b};
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            m_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule : seq_mul4

// File: tb/tb_seq_mul4.sv
module tb_seq_mul4;
    import mul_pkg::*;

    localparam int N = MUL_N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    seq_mul4 #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Accept one operation, then verify latency, busy span, done width,
    // the product value, and that product holds afterwards.
    task automatic run_op(input logic [N-1:0] ai, input logic [N-1:0] bi,
                          input logic [2*N-1:0] exp, input string tag);
        int  lat;
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        start = 1'b1; a = ai; b = bi;
        @(negedge clk);                      // after E0
        start = 1'b0; a = ~ai; b = ~bi;      // operands must already be captured
        busy_cycles = busy ? 1 : 0;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
            if (done) seen = 1;
        end
        check({tag, " latency"}, lat, N);
        check({tag, " product"}, {24'd0, product}, {24'd0, exp});
        @(negedge clk);
        check({tag, " done width"}, {31'd0, done}, 32'd0);
        check({tag, " busy span"}, busy_cycles + (busy ? 1 : 0), N + 1);
        check({tag, " product hold"}, {24'd0, product}, {24'd0, exp});
        $display("op %s: %0d x %0d -> %0h after %0d edges", tag, ai, bi, product, lat);
    endtask

    vec_t vecs[8];

    initial begin : main
        int cyc;
        int prev;
        int dones;

        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  p: 8'h00};
        vecs[4] = '{a: 4'd7,  b: 4'd6,  p: 8'h2A};
        vecs[5] = '{a: 4'd1,  b: 4'd15, p: 8'h0F};
        vecs[6] = '{a: 4'd10, b: 4'd12, p: 8'h78};
        vecs[7] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", {24'd0, product}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // start pulsed again at E2 while busy must be ignored
        @(negedge clk);
        start = 1'b1; a = 4'd13; b = 4'd11;
        @(negedge clk);                      // after E0
        start = 1'b0;
        @(negedge clk);                      // after E1
        start = 1'b1; a = 4'd3; b = 4'd3;
        @(negedge clk);                      // after E2
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                check("busy-start product", {24'd0, product}, 32'h8F);
            end
            @(negedge clk);
        end
        check("busy-start done count", dones, 1);
        check("busy-start idle after", {31'd0, busy}, 32'd0);
        $display("seq busy-start: %0d done pulse(s), product %0h", dones, product);

        // reset at E2 of a 7x6 operation
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd6;
        @(negedge clk);                      // after E0
        start = 1'b0;
        @(negedge clk);                      // after E1
        rst = 1'b1; start = 1'b1;
        @(negedge clk);                      // after E2
        rst = 1'b0; start = 1'b0;
        check("midrun rst busy", {31'd0, busy}, 32'd0);
        check("midrun rst done", {31'd0, done}, 32'd0);
        check("midrun rst product", {24'd0, product}, 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrun rst no activity", dones, 0);
        $display("seq midrun reset: busy %0b done %0b product %0h", busy, done, product);

        // start together with rst in IDLE is ignored
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst+start still idle", {31'd0, busy}, 32'd0);
        $display("seq rst+start: busy %0b", busy);

        run_op(4'd7, 4'd6, 8'h2A, "after-rst");

        // start held high: back-to-back operations every N+2 cycles
        @(negedge clk);
        start = 1'b1; a = 4'd2; b = 4'd5;
        cyc = 0; prev = -1; dones = 0;
        while (dones < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dones++;
                check("held product", {24'd0, product}, 32'h0A);
                if (prev >= 0) check("held interval", cyc - prev, N + 2);
                $display("seq held start: done at cycle %0d product %0h", cyc, product);
                prev = cyc;
            end
        end
        start = 1'b0;
        check("held done count", dones, 3);
        repeat (3) @(negedge clk);
        check("held idle after release", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_seq_mul4

// File: doc/seq_mul4.md
# seq_mul4

Sequential shift-and-add unsigned multiplier for the lab datapath, built around the 4-bit ripple-carry adder stage. Each RUN cycle it feeds the adder the multiplicand and the partial-product high half, then consumes the sum and carry-out. An N×N product is delivered after N iterations under a start/busy/done handshake. It sits between the operand registers and the result bus of the arithmetic unit.

## Interface
- N, default 4: operand width in bits (≥2); product is 2N bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  N  multiplicand, unsigned; captured on the accepting edge.
- b  input  N  multiplier, unsigned; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product valid and new.
- product  output  2N  registered a×b; holds until the next completion.

## Operation
- Internal registers:
  - M[N-1:0]: multiplicand.
  - ACC: {C, HI[N-1:0], LO[N-1:0]}, 2N+1 bits.
  - cnt: iteration counter, clog2(N+1) bits.
  - state.
- States and transitions:
  - IDLE→RUN when start=1. Load M=a, C=0, HI=0, LO=b, cnt=0.
  - RUN→RUN while cnt<N-1. Each cycle:
    - If LO[0]=1, {C,HI} = HI+M (N-bit add, carry-in 0, carry-out into C). Otherwise {C,HI} = {0,HI}.
    - Then shift {C,HI,LO} right by 1 with 0 into the MSB.
    - cnt++.
  - RUN→DONE on the iteration with cnt=N-1 (N iterations total). product ← {HI,LO} after that final shift.
  - DONE→IDLE unconditionally after one cycle.
- Handshake:
  - start is ignored in RUN and DONE. No queuing.
  - start held high continuously causes a restart on the first IDLE cycle after DONE, using the a/b present then.
  - a/b may change freely after the accepting edge.
- Arithmetic:
  - Unsigned only.
  - Overflow is impossible: (2^N-1)^2 < 2^(2N). C is consumed by the next shift, and C=0 after the final shift.
- Reset, any time including mid-RUN:
  - state=IDLE, busy=0, done=0, product=0, ACC=0, M=0, cnt=0.
  - An in-flight operation is discarded without a done pulse.
  - start asserted in the same cycle as rst is ignored.

## Timing
- Edge E0 samples start=1 in IDLE. busy=1 from E0 onward.
- Iterations occur at edges E1..EN.
- State=DONE after EN:
  - done=1 and the new product visible for exactly one cycle, EN to EN+1.
  - busy remains 1 in DONE.
- After EN+1: IDLE, busy=0, done=0, product unchanged.
- Latency is N edges from accept to done. Issue interval is N+2 cycles minimum, since the next start is sampled at EN+2.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package mul_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2. Value 3 is illegal and decodes to IDLE.
  - Default width constant MUL_N=4.
- One sub-module: rca_n, a parameterised N-bit combinational ripple-carry adder (ports a, b, ci, s, co) built from full-adder cells. It is instantiated once with ci tied to 0.
- Control FSM and datapath registers live in seq_mul4 itself.

## Test plan
- Reset, then start with a=13, b=11 → done exactly 4 edges after accept, product=8'h8F (143); busy high for 5 cycles.
- a=15, b=15 → product=8'hE1 (225). Confirm no lost carry.
- a=0, b=9 and a=9, b=0 → product=0 both times. done still pulses once each.
- Pulse start again at E2 with a=3, b=3 while busy → ignored; product=8'h8F (from 13×11), single done pulse.
- Assert rst at E2 of a 7×6 operation → no done pulse, busy=0 and product=0 the next cycle. A following 7×6 gives 8'h2A.
- Hold start=1 with a=2, b=5 → done pulses every 6 cycles with product=8'h0A each time.
